// File: rtl/uart_rate_pkg.sv
// Shared types for the UART rate-change sequencer.
package uart_rate_pkg;

  // Oversampling select codes understood by the tick generator
  typedef enum logic [1:0] {
    RATE_X16 = 2'd0,
    RATE_X8  = 2'd1,
    RATE_X4  = 2'd2,
    RATE_X2  = 2'd3
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_APPLY   = 2'd2,
    ST_RELEASE = 2'd3
  } rate_ctrl_state_e;

  localparam int SETTLE_W = 8;

endpackage

// File: rtl/uart_rate_ctrl_if.sv
// Request handshake plus TX/RX/tick-generator side signals of the rate sequencer.
// slave: the sequencer; master: the surrounding command/UART logic.
interface uart_rate_ctrl_if;
  logic       req_valid_i;
  logic [1:0] req_rate_i;
  logic       req_ready_o;
  logic       tx_busy_i;
  logic       rx_busy_i;
  logic       hold_o;
  logic [1:0] rate_o;
  logic       gen_rst_o;
  logic       done_o;
  logic       err_o;

  modport slave (
    input  req_valid_i, req_rate_i, tx_busy_i, rx_busy_i,
    output req_ready_o, hold_o, rate_o, gen_rst_o, done_o, err_o
  );

  modport master (
    output req_valid_i, req_rate_i, tx_busy_i, rx_busy_i,
    input  req_ready_o, hold_o, rate_o, gen_rst_o, done_o, err_o
  );
endinterface

// File: rtl/uart_rate_cnt.sv
// Loadable down-counter that stops at zero and flags it.
module uart_rate_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; decrement holds once zero is reached
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rate_ctrl.sv
// Run-time rate change sequencer for the UART tick generator.
// Optional DRAIN timeout: define UART_RATE_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request; same-rate requests complete here
// DRAIN   | hold TX/RX off, wait for both paths idle
// APPLY   | new rate driven, generator held in reset for the settle window
// RELEASE | one cycle: drop reset and hold, pulse done
module uart_rate_ctrl
  import uart_rate_pkg::*;
#(
  parameter logic [1:0] DEFAULT_RATE   = 2'd0,
  parameter int         SETTLE_CYCLES  = 16,
  parameter int         TIMEOUT_CYCLES = 65536
) (
  input logic            clk_i,
  input logic            rst_i,
  uart_rate_ctrl_if.slave bus
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("uart_rate_ctrl: SETTLE_CYCLES must be 2..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rate_ctrl: TIMEOUT_CYCLES must be positive");
  end

  rate_ctrl_state_e state_q;
  rate_e            rate_q;
  rate_e            new_rate_q;
  logic             ready_q;
  logic             hold_q;
  logic             gen_rst_q;
  logic             done_q;
  logic             err_q;

  logic accept;
  logic drain_idle;
  logic settle_zero;
  logic to_expire;

  assign accept     = bus.req_valid_i && ready_q;
  assign drain_idle = !bus.tx_busy_i && !bus.rx_busy_i;

  // Settle window: loaded with SETTLE_CYCLES-1 so the zero flag marks the last APPLY cycle
  uart_rate_cnt #(.W(SETTLE_W)) u_settle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     ((state_q == ST_DRAIN) && drain_idle),
    .load_val_i (SETTLE_W'(SETTLE_CYCLES - 1)),
    .dec_i      (state_q == ST_APPLY),
    .zero_o     (settle_zero)
  );

`ifdef UART_RATE_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic to_zero;

  // Timeout armed on every accept that will enter DRAIN
  uart_rate_cnt #(.W(TO_W)) u_timeout_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept && (bus.req_rate_i != rate_q)),
    .load_val_i (TO_W'(TIMEOUT_CYCLES)),
    .dec_i      (state_q == ST_DRAIN),
    .zero_o     (to_zero)
  );

  assign to_expire = to_zero;
`else
  assign to_expire = 1'b0;
`endif

  // Sequencer FSM with registered outputs; done/err default low so they pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rate_q     <= rate_e'(DEFAULT_RATE);
      new_rate_q <= rate_e'(DEFAULT_RATE);
      ready_q    <= 1'b1;
      hold_q     <= 1'b0;
      gen_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            new_rate_q <= rate_e'(bus.req_rate_i);
            ready_q    <= 1'b0;
            if (bus.req_rate_i == rate_q) begin
              done_q <= 1'b1;
            end else begin
              hold_q  <= 1'b1;
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_idle) begin
            rate_q    <= new_rate_q;
            gen_rst_q <= 1'b1;
            state_q   <= ST_APPLY;
          end else if (to_expire) begin
            err_q   <= 1'b1;
            hold_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          if (settle_zero) begin
            gen_rst_q <= 1'b0;
            hold_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.hold_o      = hold_q;
  assign bus.rate_o      = rate_q;
  assign bus.gen_rst_o   = gen_rst_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_uart_rate_ctrl.sv
// Directed bench for uart_rate_ctrl (SETTLE_CYCLES=16, DEFAULT_RATE=0).
module tb_uart_rate_ctrl;

`ifdef UART_RATE_CTRL_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65536;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  uart_rate_ctrl_if bus();

  uart_rate_ctrl #(
    .DEFAULT_RATE   (2'd0),
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    int  errs;
    int  dones;
    bit  ok;

    bus.req_valid_i = 1'b0;
    bus.req_rate_i  = 2'd0;
    bus.tx_busy_i   = 1'b0;
    bus.rx_busy_i   = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_rate",    bus.rate_o,      2'd0);
    chk("rst_ready",   bus.req_ready_o, 1'b1);
    chk("rst_hold",    bus.hold_o,      1'b0);
    chk("rst_gen_rst", bus.gen_rst_o,   1'b0);
    chk("rst_done",    bus.done_o,      1'b0);
    chk("rst_err",     bus.err_o,       1'b0);
    tick();

    // Same-rate request: done at T+1, ready back at T+2
    bus.req_valid_i = 1'b1;
    bus.req_rate_i  = 2'd0;
    tick();
    bus.req_valid_i = 1'b0;
    chk("same_done",    bus.done_o,      1'b1);
    chk("same_hold",    bus.hold_o,      1'b0);
    chk("same_gen_rst", bus.gen_rst_o,   1'b0);
    chk("same_ready_t1", bus.req_ready_o, 1'b0);
    tick();
    chk("same_done_t2",  bus.done_o,      1'b0);
    chk("same_ready_t2", bus.req_ready_o, 1'b1);
    chk("same_hold_t2",  bus.hold_o,      1'b0);

    // Rate 2, busy low: settle exactly 16 cycles, done at T+18
    bus.req_valid_i = 1'b1;
    bus.req_rate_i  = 2'd2;
    tick();
    bus.req_valid_i = 1'b0;
    chk("r2_hold_t1",    bus.hold_o,      1'b1);
    chk("r2_rate_t1",    bus.rate_o,      2'd0);
    chk("r2_gen_rst_t1", bus.gen_rst_o,   1'b0);
    chk("r2_ready_t1",   bus.req_ready_o, 1'b0);
    tick();
    chk("r2_rate_t2",    bus.rate_o,      2'd2);
    chk("r2_gen_rst_t2", bus.gen_rst_o,   1'b1);
    n  = 0;
    ok = 1'b1;
    while (bus.gen_rst_o === 1'b1 && n < 100) begin
      if (bus.hold_o !== 1'b1 || bus.done_o !== 1'b0 || bus.rate_o !== 2'd2) ok = 1'b0;
      n++;
      tick();
    end
    chk("r2_settle_len",  n,              32'd16);
    chk("r2_apply_stable", ok,            1'b1);
    chk("r2_done_t18",    bus.done_o,     1'b1);
    chk("r2_hold_t18",    bus.hold_o,     1'b0);
    chk("r2_ready_t18",   bus.req_ready_o, 1'b0);
    tick();
    chk("r2_ready_t19",   bus.req_ready_o, 1'b1);
    chk("r2_done_t19",    bus.done_o,     1'b0);

    // Rate 1 with TX busy for 40 cycles after accept; rx toggles inside the window
    bus.req_valid_i = 1'b1;
    bus.req_rate_i  = 2'd1;
    bus.tx_busy_i   = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.hold_o !== 1'b1 || bus.gen_rst_o !== 1'b0 ||
          bus.rate_o !== 2'd2 || bus.req_ready_o !== 1'b0) ok = 1'b0;
      if (i == 10) bus.rx_busy_i = 1'b1;
      if (i == 15) bus.rx_busy_i = 1'b0;
      tick();
    end
    bus.tx_busy_i = 1'b0;
    if (bus.gen_rst_o !== 1'b0 || bus.rate_o !== 2'd2) ok = 1'b0;
    chk("busy_drain_held", ok, 1'b1);
    tick();
    chk("busy_rate_apply",    bus.rate_o,    2'd1);
    chk("busy_gen_rst_apply", bus.gen_rst_o, 1'b1);
    n = 0;
    while (bus.done_o !== 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy_done_seen",  bus.done_o, 1'b1);
    chk("busy_done_delay", n,          32'd16);
    tick();
    chk("busy_ready_back", bus.req_ready_o, 1'b1);

    // Reset asserted during APPLY
    bus.req_valid_i = 1'b1;
    bus.req_rate_i  = 2'd3;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    chk("rstapply_gen_rst", bus.gen_rst_o, 1'b1);
    chk("rstapply_rate",    bus.rate_o,    2'd3);
    rst = 1'b1;
    tick();
    chk("rstmid_rate",    bus.rate_o,      2'd0);
    chk("rstmid_gen_rst", bus.gen_rst_o,   1'b0);
    chk("rstmid_hold",    bus.hold_o,      1'b0);
    chk("rstmid_done",    bus.done_o,      1'b0);
    chk("rstmid_ready",   bus.req_ready_o, 1'b1);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.done_o !== 1'b0 || bus.gen_rst_o !== 1'b0 || bus.hold_o !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("rstmid_quiet", ok, 1'b1);

`ifdef UART_RATE_CTRL_TIMEOUT_EN
    // RX stuck busy: single err pulse, rate unchanged, back to IDLE
    bus.rx_busy_i   = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_rate_i  = 2'd2;
    tick();
    bus.req_valid_i = 1'b0;
    errs  = 0;
    dones = 0;
    ok    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.err_o === 1'b1) errs++;
      if (bus.done_o === 1'b1) dones++;
      if (bus.rate_o !== 2'd0 || bus.gen_rst_o !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("to_err_pulses", errs,            32'd1);
    chk("to_no_done",    dones,           32'd0);
    chk("to_rate_kept",  ok,              1'b1);
    chk("to_hold_low",   bus.hold_o,      1'b0);
    chk("to_ready",      bus.req_ready_o, 1'b1);
    bus.rx_busy_i   = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_rate_i  = 2'd2;
    tick();
    bus.req_valid_i = 1'b0;
    chk("to_new_accept", bus.hold_o, 1'b1);
    n = 0;
    while (bus.done_o !== 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_new_done", bus.rate_o, 2'd2);
`else
    errs  = 0;
    dones = 0;
    chk("err_tied_low", bus.err_o, 1'b0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rate_ctrl.md
# uart_rate_ctrl

Sequencer that owns the `rate_i` oversampling select of the UART tick generator and changes it safely at run time. A rate-change request is accepted over a valid/ready handshake, new TX/RX activity is held off, and the block waits for both paths to go idle. It then drives the new rate while holding the generator in reset for a settle window, and releases it. It sits between the CORDIC/UART command logic and the tick generator/RX/TX instances.

## Interface
- `DEFAULT_RATE`, 2'd0: rate driven out of reset (0 = x16, 1 = x8, 2 = x4, 3 = x2).
- `SETTLE_CYCLES`, 16: cycles `gen_rst_o` is held high in APPLY; legal range is 2..255.
- `TIMEOUT_CYCLES`, 65536: DRAIN timeout; used only with `UART_RATE_CTRL_TIMEOUT_EN`.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `req_valid_i`, input, 1: rate-change request valid.
- `req_rate_i`, input, 2: requested rate code.
- `req_ready_o`, output, 1: high only in IDLE.
- `tx_busy_i`, input, 1: TX frame in progress.
- `rx_busy_i`, input, 1: RX frame in progress.
- `hold_o`, output, 1: TX/RX must not start a new frame while high.
- `rate_o`, output, 2: drives the tick generator `rate_i`.
- `gen_rst_o`, output, 1: ORed into the tick generator reset by the parent.
- `done_o`, output, 1: one-cycle pulse when a request completes.
- `err_o`, output, 1: one-cycle pulse on timeout abort; constant 0 when the timeout feature is compiled out.

## Operation
- All outputs are registered. Reset values:
  - `rate_o` = DEFAULT_RATE
  - `req_ready_o` = 1
  - `hold_o` = 0
  - `gen_rst_o` = 0
  - `done_o` = 0
  - `err_o` = 0
  - state = IDLE
- FSM states: IDLE, DRAIN, APPLY, RELEASE.
- IDLE:
  - A request is accepted when `req_valid_i && req_ready_o`, and `req_rate_i` is latched.
  - If the latched rate equals `rate_o`: the next cycle pulses `done_o`, stays in IDLE, and `hold_o`/`gen_rst_o` never assert.
  - Otherwise: go to DRAIN with `hold_o`=1.
- DRAIN:
  - Leave when `tx_busy_i==0 && rx_busy_i==0` is sampled in the same cycle; go to APPLY.
  - Busy toggling during DRAIN only delays the exit.
- APPLY:
  - `rate_o` takes the latched rate on entry.
  - `gen_rst_o`=1 for exactly SETTLE_CYCLES cycles, counted by a down-counter loaded on entry; then go to RELEASE.
- RELEASE:
  - Lasts one cycle: `gen_rst_o`=0, `hold_o`=0, `done_o`=1; then IDLE.
- `req_ready_o`=0 in every state except IDLE. Requests presented outside IDLE are not accepted and must be held by the requester.
- `rst_i` mid-operation aborts immediately to the reset values, including `rate_o` = DEFAULT_RATE. No done or err pulse is produced.
- Counter width is 8 bits for settle; timeout width is $clog2(TIMEOUT_CYCLES+1). There is no wrap: the counter saturates at 0.

## Timing
- Request accepted at cycle T:
  - Same-rate: `done_o` at T+1, `req_ready_o`=1 at T+2.
  - Different rate, busy already low: DRAIN at T+1, APPLY from T+2 to T+1+SETTLE_CYCLES, RELEASE/`done_o` at T+2+SETTLE_CYCLES, `req_ready_o`=1 at T+3+SETTLE_CYCLES.
- `hold_o` rises at T+1 and falls at the RELEASE edge (T+2+SETTLE_CYCLES).
- `rate_o` changes at T+2, which is the same edge `gen_rst_o` rises. The generator's registered increment therefore settles while it is held in reset.

## Configuration
- `UART_RATE_CTRL_TIMEOUT_EN` defined:
  - DRAIN loads a counter with TIMEOUT_CYCLES on entry.
  - If busy is still high when the counter reaches 0: `err_o` pulses for one cycle, `hold_o` drops, `rate_o` is unchanged, no `done_o` is produced, and the FSM returns to IDLE.
  - If idle and expiry occur in the same cycle, idle wins (go to APPLY).
- Not defined: DRAIN waits indefinitely, the timeout counter is absent, and `err_o` is tied to 0.

## Structure
- Package `uart_rate_pkg`:
  - rate enum `rate_e` (RATE_X16=0, RATE_X8=1, RATE_X4=2, RATE_X2=3)
  - FSM enum `rate_ctrl_state_e`
  - `SETTLE_W`=8
- Sub-module `uart_rate_cnt`: a loadable saturating down-counter with a zero flag. It is instantiated once for settle, plus once for the timeout under the macro.
- The tick generator is instantiated by the parent, not inside this block.

## Test plan
- Reset: after `rst_i` is deasserted, `rate_o`=0 and `req_ready_o`=1; all other outputs are 0.
- Req rate 2 with busy low, SETTLE_CYCLES=16: `gen_rst_o` is high for exactly 16 cycles, `rate_o`=2 from T+2, and `done_o` pulses at T+18.
- Req rate 0 while `rate_o`=0: `done_o` at T+1; `hold_o` and `gen_rst_o` never assert.
- `tx_busy_i` high for 40 cycles after accept: `hold_o` is high throughout, APPLY starts the cycle after busy falls, and `rate_o` is unchanged until then.
- With the macro and TIMEOUT_CYCLES=100, `rx_busy_i` stuck high: `err_o` pulses once, `rate_o` keeps its old value, and the block returns to IDLE; a new request is then accepted.
- `rst_i` asserted during APPLY: the next cycle has `rate_o`=DEFAULT_RATE, `gen_rst_o`=0, `hold_o`=0, and no `done_o`.
